sd_spi_cmd_engine: RTL and testbench

Downstream of the SD bring-up sequencer and upstream of the Avalon SPI core (spi_0 control port).
- Takes one SD command request (index, argument, CRC) and serialises it as a 6-byte SPI frame through the core's register interface.
- Polls the core's status register for TRDY/RRDY, then clocks 0xFF fill bytes until an R1 response (bit7 = 0) arrives or the poll budget runs out.
- Replaces the hand-stepped write sequence in the top level with a proper handshaked engine.

---
 rtl/sd_spi_cmd_engine.sv | 204 ++++++++++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_cmd_engine.sv
// SD command engine: sends one SD command as a 6-byte SPI frame through the
// Avalon SPI core register port, then polls 0xFF fill bytes for the R1 response.
module sd_spi_cmd_engine #(
  parameter int PRE_DUMMY    = 10,
  parameter int MAX_POLL     = 8,
  parameter int XFER_TIMEOUT = 65535
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        start,
  input  logic        pre_clk,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        spi_chipselect,
  output logic [2:0]  spi_address,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_writedata,
  input  logic [15:0] spi_readdata
);
  localparam int PRE_W  = (PRE_DUMMY > 0) ? $clog2(PRE_DUMMY + 1) : 1;
  localparam int POLL_W = $clog2(MAX_POLL + 1);
  localparam int WD_W   = $clog2(XFER_TIMEOUT + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_DUMMY - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLL - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(XFER_TIMEOUT);
  localparam logic [2:0] ADDR_RX = 3'd0;
  localparam logic [2:0] ADDR_TX = 3'd1;
  localparam logic [2:0] ADDR_ST = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_ST_T, S_ST_T_CHK, S_WR, S_ST_R, S_ST_R_CHK, S_RD, S_RD_CHK, S_FIN
  } state_t;
  typedef enum logic [1:0] {PH_PRE, PH_FRAME, PH_RESP} phase_t;

  state_t             state;
  phase_t             phase;
  logic [5:0]         idx_lat;
  logic [31:0]        arg_lat;
  logic [6:0]         crc_lat;
  logic [PRE_W-1:0]   pre_cnt;
  logic [2:0]         byte_cnt;
  logic [POLL_W-1:0]  poll_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic [7:0]         tx_byte;
  logic               unused_rd;

  assign unused_rd = &{1'b0, spi_readdata[15:8], spi_readdata[5:0]};

  // PRE and RESP phases clock out fill bytes; FRAME walks the latched command.
  always_comb begin
    tx_byte = 8'hFF;
    if (phase == PH_FRAME) begin
      case (byte_cnt)
        3'd0:    tx_byte = {2'b01, idx_lat};
        3'd1:    tx_byte = arg_lat[31:24];
        3'd2:    tx_byte = arg_lat[23:16];
        3'd3:    tx_byte = arg_lat[15:8];
        3'd4:    tx_byte = arg_lat[7:0];
        3'd5:    tx_byte = {crc_lat, 1'b1};
        default: tx_byte = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state          <= S_IDLE;
      phase          <= PH_FRAME;
      idx_lat        <= '0;
      arg_lat        <= '0;
      crc_lat        <= '0;
      pre_cnt        <= '0;
      byte_cnt       <= '0;
      poll_cnt       <= '0;
      wd_cnt         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      r1             <= 8'hFF;
      spi_chipselect <= 1'b0;
      spi_address    <= ADDR_RX;
      spi_read_n     <= 1'b1;
      spi_write_n    <= 1'b1;
      spi_writedata  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          spi_chipselect <= 1'b0;
          if (start) begin
            idx_lat        <= cmd_index;
            arg_lat        <= cmd_arg;
            crc_lat        <= cmd_crc;
            phase          <= (pre_clk && PRE_DUMMY > 0) ? PH_PRE : PH_FRAME;
            pre_cnt        <= '0;
            byte_cnt       <= '0;
            poll_cnt       <= '0;
            wd_cnt         <= '0;
            busy           <= 1'b1;
            timeout        <= 1'b0;
            state          <= S_ST_T;
            spi_chipselect <= 1'b1;
            spi_address    <= ADDR_ST;
            spi_read_n     <= 1'b0;
          end
        end
        S_FIN: begin
          done           <= 1'b0;
          spi_chipselect <= 1'b0;
          state          <= S_IDLE;
        end
        default: begin
          if (wd_cnt == WD_LIMIT) begin
            // Exchange watchdog: abandon the command with a timeout result.
            state       <= S_FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            r1          <= 8'hFF;
            spi_read_n  <= 1'b1;
            spi_write_n <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            case (state)
              S_ST_T: begin
                spi_read_n <= 1'b1;
                state      <= S_ST_T_CHK;
              end
              S_ST_T_CHK: begin
                if (spi_readdata[6]) begin
                  state         <= S_WR;
                  spi_address   <= ADDR_TX;
                  spi_writedata <= {8'h00, tx_byte};
                  spi_write_n   <= 1'b0;
                end else begin
                  state       <= S_ST_T;
                  spi_address <= ADDR_ST;
                  spi_read_n  <= 1'b0;
                end
              end
              S_WR: begin
                spi_write_n <= 1'b1;
                state       <= S_ST_R;
                spi_address <= ADDR_ST;
                spi_read_n  <= 1'b0;
              end
              S_ST_R: begin
                spi_read_n <= 1'b1;
                state      <= S_ST_R_CHK;
              end
              S_ST_R_CHK: begin
                spi_read_n <= 1'b0;
                if (spi_readdata[7]) begin
                  state       <= S_RD;
                  spi_address <= ADDR_RX;
                end else begin
                  state       <= S_ST_R;
                  spi_address <= ADDR_ST;
                end
              end
              S_RD: begin
                spi_read_n <= 1'b1;
                state      <= S_RD_CHK;
              end
              S_RD_CHK: begin
                if (phase == PH_RESP &&
                    (!spi_readdata[7] || poll_cnt == POLL_LAST)) begin
                  poll_cnt <= poll_cnt + 1'b1;
                  r1       <= spi_readdata[7:0];
                  timeout  <= spi_readdata[7];
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_FIN;
                end else begin
                  case (phase)
                    PH_PRE: begin
                      if (pre_cnt == PRE_LAST) phase <= PH_FRAME;
                      else pre_cnt <= pre_cnt + 1'b1;
                    end
                    PH_FRAME: begin
                      if (byte_cnt == 3'd5) phase <= PH_RESP;
                      else byte_cnt <= byte_cnt + 1'b1;
                    end
                    default: poll_cnt <= poll_cnt + 1'b1;
                  endcase
                  wd_cnt      <= '0;
                  state       <= S_ST_T;
                  spi_address <= ADDR_ST;
                  spi_read_n  <= 1'b0;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: SPI-core register model, scoreboard queues filled
// from a byte-level command model, and an independent monitor that checks them.
module tb_sd_spi_cmd_engine;
  localparam int PRE_DUMMY    = 10;
  localparam int MAX_POLL     = 8;
  localparam int XFER_TIMEOUT = 100;

  typedef struct packed {
    logic [7:0] r1;
    logic       to;
  } res_t;

  logic        CLOCK_50 = 1'b0;
  logic        KEY0 = 1'b0;
  logic        start = 1'b0;
  logic        pre_clk = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        busy, done, timeout, spi_chipselect, spi_read_n, spi_write_n;
  logic [7:0]  r1;
  logic [2:0]  spi_address;
  logic [15:0] spi_writedata, spi_readdata;

  int tests = 0;
  int fails = 0;
  int txn_no = 0;

  logic [7:0] wr_q [$];
  res_t       res_q [$];

  sd_spi_cmd_engine #(
    .PRE_DUMMY(PRE_DUMMY), .MAX_POLL(MAX_POLL), .XFER_TIMEOUT(XFER_TIMEOUT)
  ) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .start(start), .pre_clk(pre_clk),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
    .busy(busy), .done(done), .r1(r1), .timeout(timeout),
    .spi_chipselect(spi_chipselect), .spi_address(spi_address),
    .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
    .spi_writedata(spi_writedata), .spi_readdata(spi_readdata)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn_no);
    end
  endtask

  // ---------------- SPI core register model ----------------
  bit         cfg_rrdy_never = 1'b0;
  bit         cfg_stall3 = 1'b0;
  int         cfg_resp_base = 6;
  int         cfg_resp_len = 0;
  logic [7:0] cfg_resp [16];
  int         trdy_hold = 0, rrdy_hold = 0, rd_cnt = 0, wr_cnt = 0;
  int         stall_reads = 0, core_err = 0;
  logic [15:0] rd_data = 16'h0000;

  assign spi_readdata = rd_data;

  always @(posedge CLOCK_50) begin
    if (start && !busy && KEY0) begin
      rd_cnt <= 0; wr_cnt <= 0; stall_reads <= 0; trdy_hold <= 0; rrdy_hold <= 0;
    end else begin
      if (trdy_hold > 0) trdy_hold <= trdy_hold - 1;
      if (rrdy_hold > 0) rrdy_hold <= rrdy_hold - 1;
      if (spi_chipselect && !spi_read_n) begin
        case (spi_address)
          3'd2: begin
            rd_data <= {8'h00, (!cfg_rrdy_never && rrdy_hold == 0), (trdy_hold == 0), 6'h00};
            if (trdy_hold > 0) stall_reads <= stall_reads + 1;
          end
          3'd0: begin
            // Frame-phase reads return junk (often with bit7 clear) that must be ignored.
            if (rd_cnt < cfg_resp_base) rd_data <= {8'h00, 8'($urandom)};
            else if (rd_cnt - cfg_resp_base < cfg_resp_len)
              rd_data <= {8'h00, cfg_resp[rd_cnt - cfg_resp_base]};
            else rd_data <= 16'h00FF;
            rd_cnt <= rd_cnt + 1;
          end
          default: rd_data <= 16'hDEAD;
        endcase
      end
      if (spi_chipselect && !spi_write_n) begin
        if (trdy_hold > 0) core_err <= core_err + 1;
        wr_cnt <= wr_cnt + 1;
        if (cfg_stall3 && wr_cnt == 1) trdy_hold <= 20;
        rrdy_hold <= cfg_rrdy_never ? 0 : int'($urandom_range(0, 4));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         mon_err = 0, err_base = 0, done_cnt = 0;
  logic [7:0] mon_e;
  res_t       mon_r;

  always @(negedge CLOCK_50) begin
    if (KEY0) begin
      if (!spi_read_n && !spi_write_n) mon_err++;
      if ((!spi_read_n || !spi_write_n) && !spi_chipselect) mon_err++;
      if (!spi_write_n) begin
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL wr_extra: got write %h expected none (txn %0d)", spi_writedata, txn_no);
        end else begin
          mon_e = wr_q.pop_front();
          check("txdata", {13'b0, spi_address, spi_writedata}, {13'b0, 3'd1, 8'h00, mon_e});
        end
      end
      if (done) begin
        done_cnt++;
        $display("[TB] done r1=%h timeout=%0d", r1, timeout);
        if (res_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL done_extra: got done pulse expected none (txn %0d)", txn_no);
        end else begin
          mon_r = res_q.pop_front();
          check("r1", 32'(r1), 32'(mon_r.r1));
          check("timeout", 32'(timeout), 32'(mon_r.to));
          check("busy_at_done", 32'(busy), 32'd0);
          check("writes_left", 32'(wr_q.size()), 32'd0);
          check("protocol", 32'(core_err + mon_err - err_base), 32'd0);
          err_base = core_err + mon_err;
        end
      end
    end
  end

  // Reference: which bytes the card must see and what the command returns.
  task automatic push_expect(input bit pre, input logic [5:0] idx, input logic [31:0] arg,
                             input logic [6:0] crc, input bit never_rrdy);
    logic [7:0] fr [$];
    logic [7:0] b;
    res_t       r;
    bit         found;
    if (pre) for (int k = 0; k < PRE_DUMMY; k++) fr.push_back(8'hFF);
    fr.push_back({2'b01, idx});
    fr.push_back(arg[31:24]);
    fr.push_back(arg[23:16]);
    fr.push_back(arg[15:8]);
    fr.push_back(arg[7:0]);
    fr.push_back({crc, 1'b1});
    if (never_rrdy) begin
      wr_q.push_back(fr[0]);
      r.r1 = 8'hFF; r.to = 1'b1;
      res_q.push_back(r);
      return;
    end
    foreach (fr[k]) wr_q.push_back(fr[k]);
    r.r1 = 8'hFF; r.to = 1'b1; found = 1'b0;
    for (int k = 0; k < MAX_POLL && !found; k++) begin
      b = (k < cfg_resp_len) ? cfg_resp[k] : 8'hFF;
      wr_q.push_back(8'hFF);
      r.r1 = b;
      if (!b[7]) begin found = 1'b1; r.to = 1'b0; end
    end
    res_q.push_back(r);
  endtask

  task automatic drive_cmd(input bit pre, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc);
    @(negedge CLOCK_50);
    start = 1'b1; pre_clk = pre; cmd_index = idx; cmd_arg = arg; cmd_crc = crc;
    @(negedge CLOCK_50);
    start = 1'b0; pre_clk = 1'($urandom); cmd_index = 6'($urandom);
    cmd_arg = $urandom; cmd_crc = 7'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_txn(input bit pre, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input bit stall3, input bit never_rrdy,
                         input bit poke, input int bound);
    int d0, c;
    cfg_stall3 = stall3;
    cfg_rrdy_never = never_rrdy;
    cfg_resp_base = (pre ? PRE_DUMMY : 0) + 6;
    push_expect(pre, idx, arg, crc, never_rrdy);
    txn_no++;
    $display("[TB] txn %0d pre=%0d idx=%0d arg=%h crc=%h resp_len=%0d stall=%0d no_rrdy=%0d poke=%0d",
             txn_no, pre, idx, arg, crc, cfg_resp_len, stall3, never_rrdy, poke);
    d0 = done_cnt;
    drive_cmd(pre, idx, arg, crc);
    c = 1;
    while (spi_write_n && c < 40) begin @(negedge CLOCK_50); c++; end
    check("first_write_latency_ge3", 32'(c >= 3), 32'd1);
    while (done_cnt == d0 && c < bound) begin
      if (poke && c == 8) begin
        start = 1'b1; pre_clk = 1'b1; cmd_index = ~idx; cmd_arg = ~arg;
      end else begin
        start = 1'b0;
      end
      @(negedge CLOCK_50);
      c++;
    end
    start = 1'b0;
    check("done_within_bound", 32'(done_cnt != d0), 32'd1);
    repeat (poke ? 40 : 3) @(negedge CLOCK_50);
    if (stall3) check("stall_status_reads", 32'(stall_reads >= 5), 32'd1);
    wr_q.delete();
    res_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_cs"}, 32'(spi_chipselect), 32'd0);
    check({tag, "_read_n"}, 32'(spi_read_n), 32'd1);
    check({tag, "_write_n"}, 32'(spi_write_n), 32'd1);
    check({tag, "_addr"}, 32'(spi_address), 32'd0);
    check({tag, "_wdata"}, 32'(spi_writedata), 32'd0);
    check({tag, "_r1"}, 32'(r1), 32'hFF);
  endtask

  initial begin
    int d0, c, pos;
    KEY0 = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_vals("reset");
    KEY0 = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // CMD0, answer on the third poll
    cfg_resp_len = 3; cfg_resp[0] = 8'hFF; cfg_resp[1] = 8'hFF; cfg_resp[2] = 8'h01;
    run_txn(1'b0, 6'd0, 32'h0, 7'h4A, 1'b0, 1'b0, 1'b0, 600);
    // card never answers
    cfg_resp_len = 0;
    run_txn(1'b0, 6'd17, 32'h1234_5678, 7'h2B, 1'b0, 1'b0, 1'b0, 800);
    // CMD8 with 80 pre-clocks
    cfg_resp_len = 1; cfg_resp[0] = 8'h01;
    run_txn(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b0, 1'b0, 1'b0, 1500);
    // TRDY stall before the third byte
    cfg_resp_len = 2; cfg_resp[0] = 8'hFF; cfg_resp[1] = 8'h00;
    run_txn(1'b0, 6'd55, 32'hDEAD_BEEF, 7'h11, 1'b1, 1'b0, 1'b0, 1500);
    // start while busy must be ignored
    cfg_resp_len = 1; cfg_resp[0] = 8'h05;
    run_txn(1'b0, 6'd13, 32'hA5A5_0F0F, 7'h7F, 1'b0, 1'b0, 1'b1, 800);
    // RRDY never rises: exchange watchdog
    run_txn(1'b0, 6'd1, 32'h4000_0000, 7'h00, 1'b0, 1'b1, 1'b0, 120);

    // reset in the middle of the frame
    cfg_stall3 = 1'b0; cfg_rrdy_never = 1'b0; cfg_resp_base = 6;
    cfg_resp_len = 1; cfg_resp[0] = 8'h00;
    push_expect(1'b0, 6'd9, 32'h0102_0304, 7'h15, 1'b0);
    txn_no++;
    $display("[TB] txn %0d reset-abort idx=9", txn_no);
    d0 = done_cnt;
    drive_cmd(1'b0, 6'd9, 32'h0102_0304, 7'h15);
    c = 0;
    while (wr_cnt < 3 && c < 200) begin @(negedge CLOCK_50); c++; end
    check("reached_mid_frame", 32'(wr_cnt >= 3), 32'd1);
    @(posedge CLOCK_50);
    #2 KEY0 = 1'b0;
    #1 check_reset_vals("abort");
    wr_q.delete();
    res_q.delete();
    repeat (2) @(negedge CLOCK_50);
    KEY0 = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("no_partial_done", 32'(done_cnt), 32'(d0));
    cfg_resp_len = 2; cfg_resp[0] = 8'hC3; cfg_resp[1] = 8'h01;
    run_txn(1'b0, 6'd41, 32'h4000_0000, 7'h3C, 1'b0, 1'b0, 1'b0, 800);

    // randomized commands
    for (int t = 0; t < 20; t++) begin
      pos = $urandom_range(0, 9);
      cfg_resp_len = pos + 1;
      for (int k = 0; k < pos; k++) cfg_resp[k] = 8'($urandom) | 8'h80;
      cfg_resp[pos] = 8'($urandom) & 8'h7F;
      run_txn(($urandom_range(0, 3) == 0), 6'($urandom), $urandom, 7'($urandom),
              ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
